// File: rtl/dmem_hs.sv
// Word-addressed data memory behind a valid/ready request-response handshake.
// One request in flight; the response appears LATENCY cycles after acceptance.
module dmem_hs #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WIDTH/8-1:0] req_be,
    input  logic [31:0]        req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic [7:0]         err_cnt
);

    localparam int         LANES    = WIDTH / 8;
    localparam int         ADDR_LSB = $clog2(LANES);
    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [WIDTH-1:0]   r_rsp_rdata;
    logic [7:0]         r_err_cnt;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic [31:0]        w_word;
    logic [IDX_W-1:0]   w_idx;
    logic               w_misalign;
    logic               w_range_err;
    logic               w_err;
    logic               w_accept;

    assign w_word      = req_addr >> ADDR_LSB;
    assign w_idx       = w_word[IDX_W-1:0];
    assign w_misalign  = |req_addr[ADDR_LSB-1:0];
    assign w_range_err = (w_word >= 32'(DEPTH));
    assign w_err       = w_misalign | w_range_err;
    // Gated by reset so a request presented while in reset never reaches the array.
    assign w_accept    = reset & r_req_ready & req_valid;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign err_cnt   = r_err_cnt;

    // Array has no reset: contents survive reset assertion.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < LANES; b++) begin
                if (req_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_err_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state     <= WAIT;
                        r_cnt       <= CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_rsp_valid <= (CNT_INIT == 3'd0);
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (!req_we && !w_err) ? r_mem[w_idx] : '0;
                        if (w_err && r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                WAIT: begin
                    // rsp_valid rises as the counter reaches zero, so a handshake
                    // can complete straight out of WAIT without a RESP detour.
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_rsp_valid <= 1'b1;
                        end
                    end else if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
